// File: rtl/shift_word_serializer.sv
// Parallel-in/serial-out stage: takes one N-bit word on a valid/ready handshake and shifts it out
// MSB- or LSB-first, holding each bit DIV cycles; done pulses once per completed frame.
module shift_word_serializer #(
    parameter int N   = 16,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         msb_first,
    output logic         sout,
    output logic         sout_valid,
    output logic         busy,
    output logic         done
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic          msbf_q, msbf_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;

    logic in_ready_q, in_ready_d;
    logic sout_q, sout_d;
    logic sout_valid_q, sout_valid_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        msbf_d    = msbf_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d    = in;
                    msbf_d    = msb_first;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    data_d    = msbf_q ? (data_q << 1) : (data_q >> 1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from next state so every output port comes straight off a flop.
        in_ready_d   = (state_d == IDLE);
        busy_d       = (state_d == SHIFT);
        sout_valid_d = (state_d == SHIFT);
        sout_d       = (state_d == SHIFT) && (msbf_d ? data_d[N-1] : data_d[0]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            data_q       <= '0;
            msbf_q       <= 1'b0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            in_ready_q   <= 1'b1;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            msbf_q       <= msbf_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            in_ready_q   <= in_ready_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_shift_word_serializer.sv
// Bench for shift_word_serializer: two instances (DIV=1 and DIV=3) driven from vector tables,
// hand-written corner sequences and random frames checked against a bit-order model.
module tb_shift_word_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] din0, din1;
    logic        vld0, vld1, m0, m1;
    logic        rdy0, rdy1, so0, so1, sov0, sov1, bsy0, bsy1, dn0, dn1;

    shift_word_serializer #(.N(16), .DIV(1)) u_div1 (
        .clk(clk), .reset(rst_n), .in(din0), .in_valid(vld0), .in_ready(rdy0),
        .msb_first(m0), .sout(so0), .sout_valid(sov0), .busy(bsy0), .done(dn0)
    );

    shift_word_serializer #(.N(16), .DIV(3)) u_div3 (
        .clk(clk), .reset(rst_n), .in(din1), .in_valid(vld1), .in_ready(rdy1),
        .msb_first(m1), .sout(so1), .sout_valid(sov1), .busy(bsy1), .done(dn1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Packed observation: {in_ready, sout_valid, busy, done, sout}
    localparam logic [4:0] IDLE_OBS = 5'b10000;
    localparam logic [4:0] DONE_OBS = 5'b10010;

    typedef struct {
        int          sel;
        logic [15:0] w;
        logic        m;
        logic [15:0] exp_bits;  // bits in send order, first bit at [15]
        int          done_cyc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [15:0] w, input logic m, input logic v);
        if (sel == 0) begin
            din0 = w; m0 = m; vld0 = v;
        end else begin
            din1 = w; m1 = m; vld1 = v;
        end
    endtask

    function automatic logic [4:0] outs(input int sel);
        if (sel == 0) return {rdy0, sov0, bsy0, dn0, so0};
        return {rdy1, sov1, bsy1, dn1, so1};
    endfunction

    task automatic run_frame(input int sel, input logic [15:0] w, input logic m,
                             input logic [15:0] exp_bits, input int done_cyc, input bit disturb);
        int div;
        div = (done_cyc - 1) / 16;
        @(negedge clk);
        drive(sel, w, m, 1'b1);
        chk($sformatf("idle_before s%0d", sel), 32'(outs(sel)), 32'(IDLE_OBS));
        @(posedge clk);
        #1 drive(sel, ~w, ~m, 1'b0);
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(negedge clk);
            if (c < done_cyc)
                chk($sformatf("shift s%0d w%h c%0d", sel, w, c), 32'(outs(sel)),
                    32'({4'b0110, exp_bits[15 - (c - 1) / div]}));
            else if (c == done_cyc)
                chk($sformatf("done s%0d w%h", sel, w), 32'(outs(sel)), 32'(DONE_OBS));
            else
                chk($sformatf("after s%0d w%h", sel, w), 32'(outs(sel)), 32'(IDLE_OBS));
            if (disturb && c >= 2 && c <= 10)
                drive(sel, 16'($urandom), 1'($urandom), 1'($urandom));
            else
                drive(sel, ~w, ~m, 1'b0);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int ndone;
        vecs[0] = '{0, 16'hA5C3, 1'b1, 16'hA5C3, 17};
        vecs[1] = '{0, 16'h0001, 1'b0, 16'h8000, 17};
        vecs[2] = '{1, 16'h8001, 1'b1, 16'h8001, 49};
        vecs[3] = '{0, 16'hA5C3, 1'b0, 16'hC3A5, 17};
        vecs[4] = '{1, 16'h1234, 1'b0, 16'h2C48, 49};

        rst_n = 1'b0;
        drive(0, 16'h0, 1'b0, 1'b0);
        drive(1, 16'h0, 1'b0, 1'b0);
        #12;
        chk("reset s0", 32'(outs(0)), 32'(IDLE_OBS));
        chk("reset s1", 32'(outs(1)), 32'(IDLE_OBS));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_frame(vecs[i].sel, vecs[i].w, vecs[i].m, vecs[i].exp_bits, vecs[i].done_cyc, 1'b0);

        // Disturbance during cycles 2..10 must not alter the frame in flight.
        run_frame(0, 16'hA5C3, 1'b1, 16'hA5C3, 17, 1'b1);
        run_frame(1, 16'h8001, 1'b1, 16'h8001, 49, 1'b1);

        // Back-to-back: in_valid held high, second word accepted at edge 17.
        @(negedge clk);
        drive(0, 16'hFFFF, 1'b1, 1'b1);
        @(posedge clk);
        #1 drive(0, 16'h0000, 1'b1, 1'b1);
        ndone = 0;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (dn0) ndone++;
            if (c <= 16)      chk($sformatf("b2b first c%0d", c), 32'(outs(0)), 32'(5'b01101));
            else if (c == 17) chk("b2b done1", 32'(outs(0)), 32'(DONE_OBS));
            else if (c <= 33) chk($sformatf("b2b second c%0d", c), 32'(outs(0)), 32'(5'b01100));
            else if (c == 34) chk("b2b done2", 32'(outs(0)), 32'(DONE_OBS));
            else              chk("b2b idle", 32'(outs(0)), 32'(IDLE_OBS));
            if (c == 18) drive(0, 16'h0000, 1'b1, 1'b0);
        end
        chk("b2b done count", 32'(ndone), 32'd2);

        // Asynchronous reset in cycle 7 of a DIV=3 frame.
        @(negedge clk);
        drive(1, 16'hFFFF, 1'b1, 1'b1);
        @(posedge clk);
        #1 drive(1, 16'h0000, 1'b0, 1'b0);
        for (int c = 1; c <= 7; c++) @(negedge clk);
        chk("pre-reset mid frame", 32'(outs(1)), 32'(5'b01101));
        #1 rst_n = 1'b0;
        #1 chk("async reset", 32'(outs(1)), 32'(IDLE_OBS));
        @(negedge clk);
        chk("reset held", 32'(outs(1)), 32'(IDLE_OBS));
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (dn1) ndone++;
        end
        chk("no done after reset", 32'(ndone), 32'd0);
        chk("idle after reset", 32'(outs(1)), 32'(IDLE_OBS));
        run_frame(1, 16'h8001, 1'b1, 16'h8001, 49, 1'b0);

        // Random frames checked against the bit-order model.
        for (int i = 0; i < 24; i++) begin
            int          sel;
            logic [15:0] w, e;
            logic        m;
            sel = int'($urandom_range(0, 1));
            w   = 16'($urandom);
            m   = 1'($urandom);
            for (int j = 0; j < 16; j++)
                e[15 - j] = m ? w[15 - j] : w[j];
            run_frame(sel, w, m, e, (sel == 0) ? 17 : 49, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
